// File: rtl/mask_pkg.sv
// Shared types and constants for the mask scan controller.
// FSM state encoding, RGB565 field positions and default geometry.
package mask_pkg;

  localparam int          H_ACTIVE_DEF  = 640;
  localparam int          V_ACTIVE_DEF  = 480;
  localparam logic [31:0] THR_RESET_DEF = 32'd200;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SCAN  = 2'd1;
  localparam state_t S_DRAIN = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  localparam int R_HI = 15;
  localparam int R_LO = 11;
  localparam int G_HI = 10;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;

  localparam int DIFF_W = 19;

endpackage

// File: rtl/mask_raster_cnt.sv
// x/y raster counter: clr zeroes, inc advances, holds at last pixel.
// Ports: clk_25, rst_n, clr, inc in; x, y (10b), last out.
module mask_raster_cnt #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk_25,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       last
);

  logic x_end;

  assign x_end = (x == 10'(H_ACTIVE - 1));
  assign last  = x_end && (y == 10'(V_ACTIVE - 1));

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (inc && !last) begin
      if (x_end) begin
        x <= '0;
        y <= y + 10'd1;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

endmodule

// File: rtl/mask_scan_ctrl.sv
// Frame scan controller: pairs CCD/DVI pixels into the mask generator.
// Ports: start/thr in, FIFO pops, gen_* strobe, busy/frame_done/diff_count.
module mask_scan_ctrl
  import mask_pkg::*;
#(
  parameter int          H_ACTIVE  = H_ACTIVE_DEF,
  parameter int          V_ACTIVE  = V_ACTIVE_DEF,
  parameter logic [31:0] THR_RESET = THR_RESET_DEF
) (
  input  logic              clk_25,
  input  logic              rst_n,
  input  logic              start,
  input  logic              thr_wr,
  input  logic [31:0]       thr_data,
  input  logic              ccd_empty,
  input  logic [15:0]       ccd_data,
  output logic              ccd_pop,
  input  logic              dvi_empty,
  input  logic [15:0]       dvi_data,
  output logic              dvi_pop,
  output logic              gen_read,
  output logic [9:0]        gen_x,
  output logic [9:0]        gen_y,
  output logic [4:0]        gen_ccd_r,
  output logic [5:0]        gen_ccd_g,
  output logic [4:0]        gen_ccd_b,
  output logic [4:0]        gen_dvi_r,
  output logic [5:0]        gen_dvi_g,
  output logic [4:0]        gen_dvi_b,
  output logic [31:0]       gen_threshold,
  input  logic              gen_valid,
  input  logic              gen_mask,
  output logic              busy,
  output logic              frame_done,
  output logic [DIFF_W-1:0] diff_count
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] shadow;
  logic [1:0]  outst;
  logic [1:0]  outst_nxt;
  logic        fire;
  logic        start_ok;
  logic        cnt_en;
  logic        dec;
  logic        last;

  assign start_ok = (state == S_IDLE) && start;
  assign cnt_en   = (state == S_SCAN) || (state == S_DRAIN);
  assign fire     = (state == S_SCAN) && !ccd_empty && !dvi_empty;
  assign dec      = cnt_en && gen_valid && (outst != 2'd0);

  assign ccd_pop  = fire;
  assign dvi_pop  = fire;
  assign gen_read = fire;

  assign busy       = cnt_en;
  assign frame_done = (state == S_DONE);

  assign gen_ccd_r = ccd_data[R_HI:R_LO];
  assign gen_ccd_g = ccd_data[G_HI:G_LO];
  assign gen_ccd_b = ccd_data[B_HI:B_LO];
  assign gen_dvi_r = dvi_data[R_HI:R_LO];
  assign gen_dvi_g = dvi_data[G_HI:G_LO];
  assign gen_dvi_b = dvi_data[B_HI:B_LO];

  assign outst_nxt = outst + 2'(fire) - 2'(dec);

  mask_raster_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_raster (
    .clk_25 (clk_25),
    .rst_n  (rst_n),
    .clr    (start_ok),
    .inc    (fire),
    .x      (gen_x),
    .y      (gen_y),
    .last   (last)
  );

  // DRAIN exits once the result arriving this cycle retires the
  // final outstanding read, so DONE follows it directly.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_SCAN;
      S_SCAN:  if (fire && last) state_nxt = S_DRAIN;
      S_DRAIN: if (outst_nxt == 2'd0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      outst <= '0;
    end else if (start_ok) begin
      outst <= '0;
    end else begin
      outst <= outst_nxt;
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      shadow        <= THR_RESET;
      gen_threshold <= THR_RESET;
    end else begin
      if (thr_wr) shadow <= thr_data;
      if (start_ok) begin
        gen_threshold <= thr_wr ? thr_data : shadow;
      end
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      diff_count <= '0;
    end else if (start_ok) begin
      diff_count <= '0;
    end else if (cnt_en && gen_valid && !gen_mask &&
                 (diff_count != '1)) begin
      diff_count <= diff_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mask_scan_ctrl.sv
// Scoreboard bench for mask_scan_ctrl at H_ACTIVE=4, V_ACTIVE=2.
// Stimulus queues expected pixels/results; a negedge monitor checks.
module tb_mask_scan_ctrl;

  typedef struct {
    int          x;
    int          y;
    logic [31:0] thr;
  } pix_t;

  logic        clk_25 = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic        thr_wr = 0;
  logic [31:0] thr_data = 0;
  logic        ccd_empty = 1;
  logic [15:0] ccd_data = 16'hA5C3;
  logic        ccd_pop;
  logic        dvi_empty = 1;
  logic [15:0] dvi_data = 16'h1234;
  logic        dvi_pop;
  logic        gen_read;
  logic [9:0]  gen_x, gen_y;
  logic [4:0]  gen_ccd_r, gen_ccd_b, gen_dvi_r, gen_dvi_b;
  logic [5:0]  gen_ccd_g, gen_dvi_g;
  logic [31:0] gen_threshold;
  logic        gen_valid = 0;
  logic        gen_mask = 1;
  logic        busy, frame_done;
  logic [18:0] diff_count;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   fd_cnt = 0;
  pix_t q[$];
  int   fd_exp[$];
  int   rd_cycs[$];
  logic [7:0] zmask = 0;
  bit   inj = 0;
  bit   rd_s = 0;
  bit   v1 = 0;
  bit   m1 = 1;
  logic [2:0] idx_s = 0;
  int   start_cyc;

  mask_scan_ctrl #(
    .H_ACTIVE  (4),
    .V_ACTIVE  (2),
    .THR_RESET (32'd200)
  ) dut (
    .clk_25        (clk_25),
    .rst_n         (rst_n),
    .start         (start),
    .thr_wr        (thr_wr),
    .thr_data      (thr_data),
    .ccd_empty     (ccd_empty),
    .ccd_data      (ccd_data),
    .ccd_pop       (ccd_pop),
    .dvi_empty     (dvi_empty),
    .dvi_data      (dvi_data),
    .dvi_pop       (dvi_pop),
    .gen_read      (gen_read),
    .gen_x         (gen_x),
    .gen_y         (gen_y),
    .gen_ccd_r     (gen_ccd_r),
    .gen_ccd_g     (gen_ccd_g),
    .gen_ccd_b     (gen_ccd_b),
    .gen_dvi_r     (gen_dvi_r),
    .gen_dvi_g     (gen_dvi_g),
    .gen_dvi_b     (gen_dvi_b),
    .gen_threshold (gen_threshold),
    .gen_valid     (gen_valid),
    .gen_mask      (gen_mask),
    .busy          (busy),
    .frame_done    (frame_done),
    .diff_count    (diff_count)
  );

  always #20 clk_25 = ~clk_25;

  always @(posedge clk_25) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Generator model: two-cycle latency, mask=0 where zmask is set.
  always @(negedge clk_25) begin
    rd_s  = gen_read;
    idx_s = 3'(gen_y * 4 + gen_x);
  end

  always @(posedge clk_25) begin
    #2;
    gen_valid = v1 | inj;
    gen_mask  = inj ? 1'b0 : m1;
    v1 = rd_s;
    m1 = !zmask[idx_s];
    rd_s = 0;
  end

  // Monitor
  always @(negedge clk_25) begin
    if (rst_n) begin
      check("pop_eq_ccd", 32'(ccd_pop), 32'(gen_read));
      check("pop_eq_dvi", 32'(dvi_pop), 32'(gen_read));
      if (gen_read) begin
        rd_cycs.push_back(cyc);
        check("no_underflow", 32'(ccd_empty | dvi_empty), 0);
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_read: got read at x=%0d y=%0d expected none",
                   gen_x, gen_y);
        end else begin
          pix_t e;
          e = q.pop_front();
          check("gen_x", 32'(gen_x), 32'(e.x));
          check("gen_y", 32'(gen_y), 32'(e.y));
          check("gen_thr", gen_threshold, e.thr);
          check("ccd_r", 32'(gen_ccd_r), 32'h14);
          check("ccd_g", 32'(gen_ccd_g), 32'h2E);
          check("ccd_b", 32'(gen_ccd_b), 32'h03);
          check("dvi_r", 32'(gen_dvi_r), 32'h02);
          check("dvi_g", 32'(gen_dvi_g), 32'h11);
          check("dvi_b", 32'(gen_dvi_b), 32'h14);
        end
      end
      if (frame_done) begin
        fd_cnt++;
        if (fd_exp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_frame_done: got pulse expected none");
        end else begin
          check("diff_at_done", 32'(diff_count), 32'(fd_exp.pop_front()));
          if (rd_cycs.size() > 0)
            check("done_latency", 32'(cyc - rd_cycs[$]), 3);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk_25);
    #1;
  endtask

  task automatic push_frame(input logic [31:0] thr);
    for (int i = 0; i < 8; i++) q.push_back('{i % 4, i / 4, thr});
  endtask

  task automatic do_start(input bit wr, input logic [31:0] d);
    start_cyc = cyc;
    start = 1;
    thr_wr = wr;
    thr_data = d;
    tick();
    start = 0;
    thr_wr = 0;
  endtask

  task automatic wait_done(input bit toggle);
    int n0;
    int k;
    n0 = fd_cnt;
    k = 0;
    while (fd_cnt == n0 && k < 200) begin
      if (toggle) ccd_empty = ~ccd_empty;
      tick();
      k++;
    end
    ccd_empty = 0;
    checks++;
    if (fd_cnt == n0) begin
      failures++;
      $display("FAIL frame_done_timeout: got none expected pulse");
    end
  endtask

  initial begin
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_diff", 32'(diff_count), 0);
    check("rst_thr", gen_threshold, 200);
    check("rst_x", 32'(gen_x), 0);
    check("rst_y", 32'(gen_y), 0);
    check("rst_read", 32'(gen_read), 0);
    rst_n = 1;
    ccd_empty = 0;
    dvi_empty = 0;
    tick();
    tick();
    check("idle_read", 32'(gen_read), 0);

    // Frame A: continuous FIFOs, pixels 2 and 5 differ, mid-frame thr_wr
    zmask = 8'b0010_0100;
    push_frame(200);
    fd_exp.push_back(2);
    rd_cycs.delete();
    do_start(0, 0);
    check("a_busy", 32'(busy), 1);
    tick();
    tick();
    thr_wr = 1;
    thr_data = 999;
    tick();
    thr_wr = 0;
    wait_done(0);
    check("a_reads", 32'(rd_cycs.size()), 8);
    if (rd_cycs.size() == 8) begin
      check("a_first_rd", 32'(rd_cycs[0]), 32'(start_cyc + 1));
      check("a_last_rd", 32'(rd_cycs[7]), 32'(start_cyc + 8));
    end
    check("a_busy_end", 32'(busy), 0);
    check("a_thr_end", gen_threshold, 200);
    repeat (4) tick();
    check("a_diff_hold", 32'(diff_count), 2);
    inj = 1;
    tick();
    inj = 0;
    tick();
    tick();
    check("idle_inj_diff", 32'(diff_count), 2);

    // Frame B: ccd_empty toggling, threshold picks up 999
    zmask = 0;
    push_frame(999);
    fd_exp.push_back(0);
    rd_cycs.delete();
    do_start(0, 0);
    check("b_diff_clr", 32'(diff_count), 0);
    check("b_thr", gen_threshold, 999);
    wait_done(1);
    check("b_reads", 32'(rd_cycs.size()), 8);

    // Frame C: thr_wr with start, extra start in SCAN ignored
    push_frame(7);
    fd_exp.push_back(0);
    rd_cycs.delete();
    do_start(1, 7);
    check("c_thr", gen_threshold, 7);
    tick();
    start = 1;
    tick();
    start = 0;
    wait_done(0);
    check("c_reads", 32'(rd_cycs.size()), 8);

    // Frame D: abort by reset after 3 pixels
    ccd_empty = 1;
    dvi_empty = 1;
    for (int i = 0; i < 3; i++) q.push_back('{i, 0, 32'd7});
    do_start(0, 0);
    tick();
    ccd_empty = 0;
    dvi_empty = 0;
    repeat (3) tick();
    ccd_empty = 1;
    dvi_empty = 1;
    check("d_busy", 32'(busy), 1);
    check("d_x", 32'(gen_x), 3);
    ccd_empty = 0;
    dvi_empty = 0;
    rst_n = 0;
    #1;
    check("d_rst_busy", 32'(busy), 0);
    check("d_rst_done", 32'(frame_done), 0);
    check("d_rst_diff", 32'(diff_count), 0);
    check("d_rst_thr", gen_threshold, 200);
    check("d_rst_x", 32'(gen_x), 0);
    check("d_rst_y", 32'(gen_y), 0);
    check("d_rst_read", 32'(gen_read), 0);
    tick();
    tick();
    rst_n = 1;
    repeat (10) tick();
    check("d_no_done", 32'(fd_cnt), 3);
    check("pix_q_empty", 32'(q.size()), 0);
    check("fd_q_empty", 32'(fd_exp.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mask_scan_ctrl.md
MASK_SCAN_CTRL -- requirements
Module: mask_scan_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, lines per frame.
REQ-003 SHALL have parameter THR_RESET, default 32'd200, threshold after reset.
REQ-004 clk_25  in  1  system clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle frame start request.
REQ-007 thr_wr, thr_data  in  1, 32  threshold shadow write.
REQ-008 ccd_empty, ccd_data  in  1, 16  CCD pixel FIFO, first-word-fall-through, RGB565.
REQ-009 ccd_pop  out  1  CCD FIFO pop.
REQ-010 dvi_empty, dvi_data  in  1, 16  DVI pixel FIFO, first-word-fall-through, RGB565.
REQ-011 dvi_pop  out  1  DVI FIFO pop.
REQ-012 gen_read  out  1  pixel-pair strobe to the mask generator.
REQ-013 gen_x, gen_y  out  10, 10  pixel coordinates for the strobed pair.
REQ-014 gen_ccd_r/g/b, gen_dvi_r/g/b  out  5/6/5 each  colour fields taken from ccd_data/dvi_data [15:11]/[10:5]/[4:0].
REQ-015 gen_threshold  out  32  active threshold.
REQ-016 gen_valid, gen_mask  in  1, 1  generator result; mask=0 means the pixel differs.
REQ-017 busy  out  1  frame in progress.
REQ-018 frame_done  out  1  one-cycle end-of-frame pulse.
REQ-019 diff_count  out  19  count of gen_mask=0 results in the current/last frame.

Function
REQ-020 SHALL implement FSM IDLE, SCAN, DRAIN, DONE.
REQ-021 IDLE: start=1 -> SCAN; x=y=0, diff_count=0, gen_threshold<=shadow; busy=1 from the next cycle.
REQ-022 start outside IDLE SHALL be ignored.
REQ-023 thr_wr SHALL update the shadow in any state; thr_wr and start in the same cycle SHALL load thr_data into gen_threshold.
REQ-024 SCAN: fire = !ccd_empty && !dvi_empty; ccd_pop, dvi_pop and gen_read SHALL be combinational and all equal to fire; all three are 0 outside SCAN.
REQ-025 gen_x/gen_y SHALL be registered raster counters, valid whenever gen_read=1; colour outputs pass straight from the FIFO heads.
REQ-026 On fire: x++; at x=H_ACTIVE-1, x wraps to 0 and y++.
REQ-027 Fire at (H_ACTIVE-1, V_ACTIVE-1) -> DRAIN; the counters do not advance past the last pixel.
REQ-028 A 2-bit outstanding counter SHALL increment on fire and decrement on gen_valid; a simultaneous fire and gen_valid leaves it unchanged.
REQ-029 Generator latency is 2 cycles from gen_read to gen_valid; outstanding SHALL never exceed 2.
REQ-030 DRAIN: when outstanding=0 and no gen_valid is pending, SHALL go to DONE.
REQ-031 DONE: frame_done=1 for one cycle, busy=0, then IDLE.
REQ-032 gen_valid && !gen_mask in SCAN or DRAIN SHALL increment diff_count, saturating at 2^19-1; gen_valid in IDLE/DONE SHALL be ignored.
REQ-033 diff_count SHALL hold its value from DONE until the next accepted start.
REQ-034 FIFO underflow SHALL be impossible: a pop only occurs when the FIFO is non-empty.

Reset
REQ-035 On rst_n=0: state=IDLE, x=y=0, outstanding=0, diff_count=0, shadow=gen_threshold=THR_RESET, busy=0, frame_done=0.
REQ-036 Reset mid-frame SHALL abort the frame without a frame_done pulse; FIFO contents are not flushed by this block.

Structure
REQ-037 Package mask_pkg SHALL hold the FSM state type, the RGB565 field bit positions, and the H_ACTIVE/V_ACTIVE/THR_RESET defaults.
REQ-038 The x/y raster counter SHALL be sub-module mask_raster_cnt (inputs inc and clr; outputs x, y and last).

Verification (H_ACTIVE=4, V_ACTIVE=2)
REQ-039 Both FIFOs always non-empty, start -> 8 consecutive gen_read with (0,0)..(3,0),(0,1)..(3,1), and frame_done 3 cycles after the last gen_read.
REQ-040 ccd_empty toggling every other cycle -> gen_read/ccd_pop/dvi_pop only in cycles with ccd_empty=0; still exactly 8 pops.
REQ-041 Generator model returns mask=0 for pixels 2 and 5 -> diff_count=2 at frame_done, held until the next start.
REQ-042 thr_wr 32'd999 mid-frame -> gen_threshold stays 200 for that frame and becomes 999 on the next start; thr_wr 32'd7 with start -> gen_threshold=7.
REQ-043 start during SCAN -> ignored, no counter reset; rst_n low after 3 pixels -> all outputs at reset values, no frame_done.
REQ-044 gen_valid injected in IDLE -> diff_count unchanged.
